// File: rtl/segment_reader_if.sv
// Bundle of 7-segment tap inputs and the reconstructed-frame valid/ready output.
// Pure wiring: no logic, no latency.
// out_ready is driven by the consumer; out_err only exists with SEGMENT_READER_ERR_EN.
interface segment_reader_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   dig_en;
    logic [6:0]          seg;
    logic [4*DIGITS-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_ovf;
`ifdef SEGMENT_READER_ERR_EN
    logic                out_err;

    modport master (
        output dig_en, seg, out_ready,
        input  out_data, out_valid, out_ovf, out_err
    );
    modport slave (
        input  dig_en, seg, out_ready,
        output out_data, out_valid, out_ovf, out_err
    );
`else
    modport master (
        output dig_en, seg, out_ready,
        input  out_data, out_valid, out_ovf
    );
    modport slave (
        input  dig_en, seg, out_ready,
        output out_data, out_valid, out_ovf
    );
`endif
endinterface

// File: rtl/segment_reader.sv
// Reconstructs the hex frame shown on a multiplexed 7-segment bus (optional SEGMENT_READER_ERR_EN adds out_err).
// Latency: out_valid rises the cycle after the STABLE-th identical cycle of the last digit to fill.
// Backpressure: a frame completing while the held frame is not being accepted is dropped and flagged on out_ovf.
module segment_reader #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic           clk,
    input  logic           rst,
    segment_reader_if.slave bus
);
    localparam int FW = 4 * DIGITS;
    localparam logic [3:0] STABLE_L = 4'(STABLE);

    logic [DIGITS+6:0] prev;
    logic [3:0]        run_len;
    logic [3:0]        run_len_nxt;
    logic [DIGITS-1:0] fill;
    logic [DIGITS-1:0] fill_nxt;
    logic [FW-1:0]     acc;
    logic [FW-1:0]     acc_nxt;
    logic              onehot;
    logic              same;
    logic              capture;
    logic              frame_done;
    logic              load;
    logic [3:0]        nib;

    // Inverse of the hex-to-segment decoder; unknown patterns map to 0.
    function automatic logic [3:0] seg_to_nibble(input logic [6:0] s);
        case (s)
            7'b1111110: return 4'h0;
            7'b0110000: return 4'h1;
            7'b1101101: return 4'h2;
            7'b1111001: return 4'h3;
            7'b0110011: return 4'h4;
            7'b1011011: return 4'h5;
            7'b1011111: return 4'h6;
            7'b1110000: return 4'h7;
            7'b1111111: return 4'h8;
            7'b1110011: return 4'h9;
            7'b1110111: return 4'hA;
            7'b0011111: return 4'hB;
            7'b1001110: return 4'hC;
            7'b0111101: return 4'hD;
            7'b1001111: return 4'hE;
            7'b1000111: return 4'hF;
            default:    return 4'h0;
        endcase
    endfunction

    // Run tracking, single capture per run, slot merge and frame-complete/load decision.
    always_comb begin
        onehot = $onehot(bus.dig_en);
        same   = onehot && ({bus.dig_en, bus.seg} == prev);
        nib    = seg_to_nibble(bus.seg);
        if (same) begin
            run_len_nxt = (run_len == STABLE_L) ? run_len : run_len + 4'd1;
        end else begin
            run_len_nxt = onehot ? 4'd1 : 4'd0;
        end
        // A saturated run that continues must not capture again.
        capture  = onehot && (run_len_nxt == STABLE_L) && !(same && run_len == STABLE_L);
        fill_nxt = fill;
        acc_nxt  = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && bus.dig_en[i]) begin
                fill_nxt[i]       = 1'b1;
                acc_nxt[4*i +: 4] = nib;
            end
        end
        frame_done = capture && (&fill_nxt);
        load       = frame_done && (!bus.out_valid || bus.out_ready);
    end

    // Previous strobe/pattern and saturating run length.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= '0;
            run_len <= 4'd0;
        end else begin
            prev    <= {bus.dig_en, bus.seg};
            run_len <= run_len_nxt;
        end
    end

    // Slot accumulator; fill restarts as soon as a frame completes, stale nibbles are always rewritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill <= '0;
            acc  <= '0;
        end else begin
            fill <= frame_done ? '0 : fill_nxt;
            acc  <= acc_nxt;
        end
    end

    // Output register: load a finished frame, clear on accept, flag drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_ovf   <= 1'b0;
        end else begin
            bus.out_ovf <= frame_done && !load;
            if (load) begin
                bus.out_data  <= acc_nxt;
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef SEGMENT_READER_ERR_EN
    logic err_acc;
    logic invalid;

    // Anything decoding to 0 other than the real "0" glyph is an invalid pattern.
    always_comb begin
        invalid = (nib == 4'h0) && (bus.seg != 7'b1111110);
    end

    // Sticky per-frame error, registered alongside the frame data.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_acc     <= 1'b0;
            bus.out_err <= 1'b0;
        end else begin
            if (frame_done) begin
                err_acc <= 1'b0;
            end else if (capture) begin
                err_acc <= err_acc | invalid;
            end
            if (load) begin
                bus.out_err <= err_acc | (capture & invalid);
            end
        end
    end
`endif
endmodule

// File: tb/tb_segment_reader.sv
// Self-checking bench for segment_reader: directed table, corner sequences, random traffic vs. a reference model.
// Every cycle is compared against the model; directed steps add fixed expectations.
// out_ready is driven both steadily and randomly to exercise drops and accepts.
module tb_segment_reader;
    localparam int DIGITS = 4;
    localparam int STABLE = 3;

    logic clk;
    logic rst;
    segment_reader_if #(.DIGITS(DIGITS)) bus ();

    segment_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [6:0] pat [16];

    // Reference model state (spec-level: unbounded run length, per-slot arrays).
    int         m_run;
    logic [3:0] m_pd;
    logic [6:0] m_ps;
    logic [3:0] m_nib [4];
    logic [3:0] m_fill;
    logic       m_err_acc;
    logic       m_vld;
    logic [15:0] m_dat;
    logic       m_ovf;
    logic       m_err;

    typedef struct {
        logic [3:0]  dig;
        logic [6:0]  seg;
        logic        rdy;
        int          cyc;
        logic        exp_vld;
        logic [15:0] exp_dat;
        logic        exp_ovf;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ref_decode(input logic [6:0] s, output logic [3:0] n, output logic inv);
        n   = 4'h0;
        inv = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (pat[k] == s) begin
                n   = 4'(k);
                inv = 1'b0;
            end
        end
    endtask

    task automatic model(input logic [3:0] d, input logic [6:0] s, input logic r, input logic rs);
        logic        oh;
        logic        done;
        logic [3:0]  n;
        logic        inv;
        logic [15:0] frame;
        logic        ferr;
        if (rs) begin
            m_run = 0; m_pd = '0; m_ps = '0; m_fill = '0; m_err_acc = 1'b0;
            for (int k = 0; k < 4; k++) m_nib[k] = 4'h0;
            m_vld = 1'b0; m_dat = '0; m_ovf = 1'b0; m_err = 1'b0;
        end else begin
            m_ovf = 1'b0;
            done  = 1'b0;
            frame = '0;
            ferr  = 1'b0;
            oh    = ($countones(d) == 1);
            if (oh && d == m_pd && s == m_ps) m_run++;
            else m_run = oh ? 1 : 0;
            m_pd = d;
            m_ps = s;
            if (oh && m_run == STABLE) begin
                ref_decode(s, n, inv);
                for (int k = 0; k < 4; k++) begin
                    if (d[k]) begin
                        m_nib[k]  = n;
                        m_fill[k] = 1'b1;
                    end
                end
                m_err_acc = m_err_acc | inv;
                if (m_fill == 4'hF) begin
                    done      = 1'b1;
                    frame     = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                    ferr      = m_err_acc;
                    m_fill    = '0;
                    m_err_acc = 1'b0;
                end
            end
            if (done && (!m_vld || r)) begin
                m_vld = 1'b1;
                m_dat = frame;
                m_err = ferr;
            end else if (done) begin
                m_ovf = 1'b1;
            end else if (m_vld && r) begin
                m_vld = 1'b0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, compare outputs just after the edge.
    task automatic step(input logic [3:0] d, input logic [6:0] s, input logic r, input logic rs);
        bus.dig_en    = d;
        bus.seg       = s;
        bus.out_ready = r;
        rst           = rs;
        @(posedge clk);
        model(d, s, r, rs);
        #1;
        chk("cyc_valid", 32'(bus.out_valid), 32'(m_vld));
        chk("cyc_ovf",   32'(bus.out_ovf),   32'(m_ovf));
        if (m_vld) chk("cyc_data", 32'(bus.out_data), 32'(m_dat));
`ifdef SEGMENT_READER_ERR_EN
        if (m_vld) chk("cyc_err", 32'(bus.out_err), 32'(m_err));
`endif
    endtask

    task automatic run_digit(input int idx, input logic [6:0] s, input int n, input logic r);
        for (int c = 0; c < n; c++) step(4'(1 << idx), s, r, 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] val, input logic r);
        logic [3:0] h;
        for (int i = 0; i < 4; i++) begin
            h = val[4*i +: 4];
            run_digit(i, pat[h], STABLE, r);
        end
    endtask

    initial begin
        pat = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

        tbl[0]  = '{4'b0001, 7'b0110000, 1'b1, 4, 1'b0, 16'h0000, 1'b0};
        tbl[1]  = '{4'b0010, 7'b1101101, 1'b1, 4, 1'b0, 16'h0000, 1'b0};
        tbl[2]  = '{4'b0100, 7'b1111001, 1'b1, 4, 1'b0, 16'h0000, 1'b0};
        tbl[3]  = '{4'b1000, 7'b0110011, 1'b1, 3, 1'b1, 16'h4321, 1'b0};
        tbl[4]  = '{4'b1000, 7'b0110011, 1'b1, 1, 1'b0, 16'h4321, 1'b0};
        tbl[5]  = '{4'b0001, 7'b1111111, 1'b1, 2, 1'b0, 16'h4321, 1'b0};
        tbl[6]  = '{4'b0001, 7'b1111110, 1'b1, 3, 1'b0, 16'h4321, 1'b0};
        tbl[7]  = '{4'b0010, 7'b1111111, 1'b1, 3, 1'b0, 16'h4321, 1'b0};
        tbl[8]  = '{4'b0100, 7'b1111111, 1'b1, 3, 1'b0, 16'h4321, 1'b0};
        tbl[9]  = '{4'b1000, 7'b1111111, 1'b1, 3, 1'b1, 16'h8880, 1'b0};
        tbl[10] = '{4'b0000, 7'b0000000, 1'b1, 1, 1'b0, 16'h8880, 1'b0};
        tbl[11] = '{4'b0001, 7'b0110000, 1'b1, 3, 1'b0, 16'h8880, 1'b0};
        tbl[12] = '{4'b0010, 7'b1101101, 1'b1, 3, 1'b0, 16'h8880, 1'b0};
        tbl[13] = '{4'b0100, 7'b1111001, 1'b1, 3, 1'b0, 16'h8880, 1'b0};
        tbl[14] = '{4'b0011, 7'b0110011, 1'b1, 5, 1'b0, 16'h8880, 1'b0};
        tbl[15] = '{4'b1000, 7'b1111001, 1'b1, 3, 1'b1, 16'h3321, 1'b0};
        tbl[16] = '{4'b0000, 7'b0000000, 1'b1, 1, 1'b0, 16'h3321, 1'b0};

        // Reset state
        step(4'b0000, 7'b0, 1'b1, 1'b1);
        step(4'b0000, 7'b0, 1'b1, 1'b1);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data",  32'(bus.out_data),  32'd0);
        chk("rst_ovf",   32'(bus.out_ovf),   32'd0);

        // Directed table: basic frame, glitch rejection, multi-hot strobe
        for (int r = 0; r < 17; r++) begin
            for (int c = 0; c < tbl[r].cyc; c++) step(tbl[r].dig, tbl[r].seg, tbl[r].rdy, 1'b0);
            chk($sformatf("tbl%0d_valid", r), 32'(bus.out_valid), 32'(tbl[r].exp_vld));
            chk($sformatf("tbl%0d_data", r),  32'(bus.out_data),  32'(tbl[r].exp_dat));
            chk($sformatf("tbl%0d_ovf", r),   32'(bus.out_ovf),   32'(tbl[r].exp_ovf));
        end

        // Backpressure: second frame dropped while first is held
        send_frame(16'h1234, 1'b0);
        chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_first_data",  32'(bus.out_data),  32'h1234);
        send_frame(16'hABCD, 1'b0);
        chk("bp_drop_ovf",   32'(bus.out_ovf),   32'd1);
        chk("bp_drop_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_drop_data",  32'(bus.out_data),  32'h1234);
        step(4'b0000, 7'b0, 1'b0, 1'b0);
        chk("bp_ovf_pulse",  32'(bus.out_ovf),   32'd0);
        chk("bp_hold_data",  32'(bus.out_data),  32'h1234);
        step(4'b0000, 7'b0, 1'b1, 1'b0);
        chk("bp_accept_valid", 32'(bus.out_valid), 32'd0);

        // Invalid pattern on digit 2 decodes to 0
        run_digit(0, pat[1], STABLE, 1'b1);
        run_digit(1, pat[2], STABLE, 1'b1);
        run_digit(2, 7'b0000001, STABLE, 1'b1);
        run_digit(3, pat[3], STABLE, 1'b1);
        chk("inv_data", 32'(bus.out_data), 32'h3021);
`ifdef SEGMENT_READER_ERR_EN
        chk("inv_err", 32'(bus.out_err), 32'd1);
`endif
        send_frame(16'h5A5A, 1'b1);
        chk("clean_data", 32'(bus.out_data), 32'h5A5A);
`ifdef SEGMENT_READER_ERR_EN
        chk("clean_err", 32'(bus.out_err), 32'd0);
`endif

        // Reset mid-frame discards the partial slots
        run_digit(0, pat[5], STABLE, 1'b1);
        run_digit(1, pat[6], STABLE, 1'b1);
        step(4'b0000, 7'b0, 1'b1, 1'b1);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_data",  32'(bus.out_data),  32'd0);
        run_digit(2, pat[7], STABLE, 1'b1);
        run_digit(3, pat[8], STABLE, 1'b1);
        chk("midrst_partial_valid", 32'(bus.out_valid), 32'd0);
        run_digit(0, pat[9], STABLE, 1'b1);
        chk("midrst_three_valid", 32'(bus.out_valid), 32'd0);
        run_digit(1, pat[10], STABLE, 1'b1);
        chk("midrst_full_valid", 32'(bus.out_valid), 32'd1);
        chk("midrst_full_data",  32'(bus.out_data),  32'h87A9);

        // Random traffic against the model
        for (int b = 0; b < 300; b++) begin
            logic [3:0] d;
            logic [6:0] s;
            int sel;
            int len;
            sel = $urandom_range(0, 9);
            if (sel < 8) d = 4'(1 << $urandom_range(0, 3));
            else if (sel == 8) d = 4'b0000;
            else d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 8) s = pat[$urandom_range(0, 15)];
            else s = 7'($urandom_range(0, 127));
            len = $urandom_range(1, 5);
            for (int c = 0; c < len; c++) begin
                step(d, s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/segment_reader.md
# segment_reader

Reads back a multiplexed 7-segment display bus and reconstructs the hex value that drove it. It is the decode-direction counterpart of the team's 4-bit-to-segment decoder. Per-digit patterns are sampled under a digit strobe, qualified by a stability filter, mapped back to nibbles, assembled into a frame and emitted through a valid/ready output register. It sits between a display scan driver (or an external display tap) and any consumer that needs the shown value, e.g. self-check logic or a debug readout.

## Interface
- `DIGITS`, default 4: number of multiplexed digits; frame width is 4*DIGITS.
- `STABLE`, default 3: consecutive identical cycles required before a digit is captured; legal range 1..15.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dig_en`  in  DIGITS  digit strobe, active high; bit i selects digit i; legal only when one-hot.
- `seg`  in  7  segment pattern {a,b,c,d,e,f,g}, a = bit 6, active high.
- `out_data`  out  4*DIGITS  frame; digit i occupies bits [4i+3:4i].
- `out_valid`  out  1  frame held in output register.
- `out_ready`  in  1  consumer accepts frame when out_valid && out_ready.
- `out_ovf`  out  1  one-cycle pulse when a completed frame is dropped.
- `out_err`  out  1  present only with SEGMENT_READER_ERR_EN; frame contained an invalid pattern.

## Operation
- Decode map (abcdefg -> nibble): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1110011->9, 1110111->A, 0011111->B, 1001110->C, 0111101->D, 1001111->E, 1000111->F. Any other pattern is invalid and decodes to 0.
- Run tracker: registers prev {dig_en,seg} and run counter L (4 bits, saturating at STABLE). Cycle with dig_en one-hot and {dig_en,seg} equal to prev: L increments. Otherwise L = 1 if dig_en one-hot, else 0.
- Capture: on the edge where L becomes STABLE (exactly once per run), the decoded nibble is written to slot i of the accumulator, fill[i] is set, and err_acc |= invalid.
- Re-capture of an already filled slot (new run on the same digit) overwrites the nibble; err_acc is not cleared.
- dig_en zero or multi-hot: no capture; L is cleared.
- Frame complete: after the capture edge, all fill bits would be set. On that same edge, fill and err_acc are cleared.
  - Output register empty, or out_valid && out_ready this cycle: the frame loads into out_data/out_err and out_valid is set.
  - Otherwise the frame is dropped, out_ovf pulses for one cycle, and out_data is unchanged.
- Accept: out_valid && out_ready with no simultaneous load clears out_valid. With a simultaneous load, out_valid stays 1 and carries the new data.

## Timing
- Reset values: out_data = 0, out_valid = 0, out_ovf = 0, out_err = 0, fill = 0, err_acc = 0, L = 0, prev = 0.
- Latency: out_valid is asserted in the cycle after the STABLE-th identical cycle of the last-filled digit.
- STABLE=1: capture on the first cycle of every run.
- A run longer than STABLE produces no further captures. Changing seg or dig_en restarts the run.
- rst mid-frame discards partial slots and any held frame. The first capture after reset needs a full STABLE run, counted from the first cycle rst is low.
- out_data/out_err are stable while out_valid && !out_ready.

## Configuration
- `SEGMENT_READER_ERR_EN` defined: err_acc and the out_err port exist. out_err travels with the frame and is registered alongside out_data.
- Not defined: no out_err port and no err_acc. Invalid patterns silently decode to 0 and are indistinguishable from a valid "0" digit at the output.

## Test plan
- DIGITS=4, STABLE=3, out_ready=1. Strobe digits 0..3 for 4 cycles each with patterns 0110000, 1101101, 1111001, 0110011. Required: out_data=16'h4321 and out_valid=1 for exactly one cycle, the cycle after the 3rd cycle of digit 3.
- Glitch: digit 0 shows 1111111 for 2 cycles, then 1111110 for 3 cycles; other digits show 8. Required: frame 16'h8880.
- Backpressure: out_ready=0 while two full frames (16'h1234, then 16'hABCD) complete. Required: out_data holds 16'h1234, out_ovf pulses once at the second completion, out_valid stays 1. Raising out_ready for one cycle clears out_valid.
- With ERR_EN: digit 2 shows 0000001. Required: nibble 2 = 0 and out_err=1 for that frame; the next clean frame gives out_err=0.
- dig_en=4'b0011 for 5 cycles: no capture, fill unchanged, out_valid stays 0.
- Capture digits 0 and 1, assert rst for 1 cycle, then strobe digits 2 and 3 only. Required: no out_valid. All four digits are needed afterwards before out_valid asserts.
